// File: rtl/armazenando_pecas.sv
// ---------------------------------------------------------------------------
// armazenando_pecas
//
// Board storage and conflict checker for the ship-placement phase.
// The block accepts one placement request per `valida` strobe. It checks each
// cell of the ship against the selected player's 8x8 board, one cell per
// cycle. If every cell is clear, a second pass writes the ship into the board
// one cell per cycle. The block then reports the result with `conflito` and a
// one-cycle `pronto` strobe. It counts accepted ships per player and provides
// a registered read port for the attack phase.
//
// Parameters:
//   NUM_PECAS         ships per player; once reached, completo[j] rejects
//                     further requests for player j
//
// Ports:
//   clk               system clock, rising edge
//   reset             asynchronous, active-low reset
//   enable            gates acceptance of new requests only
//   limpar            synchronous clear of boards, counters and conflito
//   valida            request strobe, sampled only while idle
//   tipo[2:0]         ship type 0..4 -> length 5..1; 5..7 are rejected
//   jogador           target board
//   X1[2:0], Y1[2:0]  first cell of the ship
//   direcao           0 = X varies, 1 = Y varies
//   orientacao        0 = increasing, 1 = decreasing coordinate
//   conflito          result of the last completed request
//   pronto            one-cycle completion strobe
//   ocupado           high while a request is in progress
//   completo[1:0]     bit j set when player j holds NUM_PECAS ships
//   consulta_jogador  read-port board select
//   consulta_x/_y     read-port cell
//   ocupada           registered board bit at Y*8+X (read-before-write)
//
// Build option:
//   ADJACENCIA_EN     when defined, a checked cell also conflicts if any
//                     in-board neighbour is occupied, so ships may not touch
// ---------------------------------------------------------------------------
module armazenando_pecas #(
    parameter int NUM_PECAS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       limpar,
    input  logic       valida,
    input  logic [2:0] tipo,
    input  logic       jogador,
    input  logic [2:0] X1,
    input  logic [2:0] Y1,
    input  logic       direcao,
    input  logic       orientacao,
    output logic       conflito,
    output logic       pronto,
    output logic       ocupado,
    output logic [1:0] completo,
    input  logic       consulta_jogador,
    input  logic [2:0] consulta_x,
    input  logic [2:0] consulta_y,
    output logic       ocupada
);

    localparam int CW = (NUM_PECAS < 1) ? 1 : $clog2(NUM_PECAS + 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITE,
        DONE
    } estado_t;

    estado_t       state_q, state_d;
    logic [2:0]    i_q, i_d;
    logic [2:0]    len_q, len_d;
    logic          jog_q, jog_d;
    logic [2:0]    x_q, x_d;
    logic [2:0]    y_q, y_d;
    logic          dir_q, dir_d;
    logic          ori_q, ori_d;
    logic [63:0]   tab_q [2];
    logic [63:0]   tab_d [2];
    logic [CW-1:0] cont_q [2];
    logic [CW-1:0] cont_d [2];
    logic          conflito_q, conflito_d;
    logic          ocupada_q, ocupada_d;

    // Geometry of the current cell i
    logic [2:0] inicio;
    logic [3:0] coord;
    logic       fora;
    logic [2:0] cx, cy;
    logic [5:0] idx;
    logic       ocup;
    logic       vizinho;
    logic       ultimo;

`ifdef ADJACENCIA_EN
    // Scans the 3x3 window around (px,py). The centre cell is included;
    // if it is occupied the overlap test would flag it anyway.
    // Out-of-board neighbours wrap to a 4-bit value with bit 3 set and are
    // skipped.
    function automatic logic vizinho_ocupado(input logic [63:0] tab,
                                             input logic [2:0]  px,
                                             input logic [2:0]  py);
        logic [3:0] nx;
        logic [3:0] ny;
        logic       hit;
        hit = 1'b0;
        for (int unsigned dy = 0; dy < 3; dy++) begin
            for (int unsigned dx = 0; dx < 3; dx++) begin
                nx = {1'b0, px} + 4'(dx) - 4'd1;
                ny = {1'b0, py} + 4'(dy) - 4'd1;
                if (!nx[3] && !ny[3] && tab[{ny[2:0], nx[2:0]}]) begin
                    hit = 1'b1;
                end
            end
        end
        return hit;
    endfunction
`endif

    always_comb begin
        inicio = dir_q ? y_q : x_q;
        // 4-bit arithmetic: 0-1 -> 15 and 7+1 -> 8 both set bit 3
        if (ori_q) begin
            coord = {1'b0, inicio} - {1'b0, i_q};
        end else begin
            coord = {1'b0, inicio} + {1'b0, i_q};
        end
        fora   = coord[3];
        cx     = dir_q ? x_q : coord[2:0];
        cy     = dir_q ? coord[2:0] : y_q;
        idx    = {cy, cx};
        ocup   = tab_q[jog_q][idx];
        ultimo = (i_q == len_q - 3'd1);
`ifdef ADJACENCIA_EN
        vizinho = vizinho_ocupado(tab_q[jog_q], cx, cy);
`else
        vizinho = 1'b0;
`endif
    end

    always_comb begin
        for (int unsigned j = 0; j < 2; j++) begin
            completo[j] = (cont_q[j] == CW'(NUM_PECAS));
        end
    end

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        len_d      = len_q;
        jog_d      = jog_q;
        x_d        = x_q;
        y_d        = y_q;
        dir_d      = dir_q;
        ori_d      = ori_q;
        tab_d      = tab_q;
        cont_d     = cont_q;
        conflito_d = conflito_q;
        ocupada_d  = tab_q[consulta_jogador][{consulta_y, consulta_x}];

        if (limpar) begin
            state_d    = IDLE;
            i_d        = '0;
            tab_d[0]   = '0;
            tab_d[1]   = '0;
            cont_d[0]  = '0;
            cont_d[1]  = '0;
            conflito_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (enable && valida) begin
                        jog_d = jogador;
                        x_d   = X1;
                        y_d   = Y1;
                        dir_d = direcao;
                        ori_d = orientacao;
                        len_d = 3'd5 - tipo;
                        i_d   = '0;
                        if (tipo > 3'd4 || completo[jogador]) begin
                            conflito_d = 1'b1;
                            state_d    = DONE;
                        end else begin
                            conflito_d = 1'b0;
                            state_d    = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (fora || ocup || vizinho) begin
                        conflito_d = 1'b1;
                        state_d    = DONE;
                    end else if (ultimo) begin
                        i_d     = '0;
                        state_d = WRITE;
                    end else begin
                        i_d = i_q + 3'd1;
                    end
                end
                WRITE: begin
                    tab_d[jog_q][idx] = 1'b1;
                    if (ultimo) begin
                        state_d = DONE;
                    end else begin
                        i_d = i_q + 3'd1;
                    end
                end
                DONE: begin
                    if (!conflito_q) begin
                        cont_d[jog_q] = cont_q[jog_q] + CW'(1);
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            i_q        <= '0;
            len_q      <= '0;
            jog_q      <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            dir_q      <= 1'b0;
            ori_q      <= 1'b0;
            tab_q[0]   <= '0;
            tab_q[1]   <= '0;
            cont_q[0]  <= '0;
            cont_q[1]  <= '0;
            conflito_q <= 1'b0;
            ocupada_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            len_q      <= len_d;
            jog_q      <= jog_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dir_q      <= dir_d;
            ori_q      <= ori_d;
            tab_q[0]   <= tab_d[0];
            tab_q[1]   <= tab_d[1];
            cont_q[0]  <= cont_d[0];
            cont_q[1]  <= cont_d[1];
            conflito_q <= conflito_d;
            ocupada_q  <= ocupada_d;
        end
    end

    assign conflito = conflito_q;
    assign pronto   = (state_q == DONE);
    assign ocupado  = (state_q != IDLE);
    assign ocupada  = ocupada_q;

endmodule

// File: tb/tb_armazenando_pecas.sv
// Self-checking bench for armazenando_pecas. The reference model keeps each
// board as a 64-bit vector plus per-player ship counts. For every request it
// derives the expected latency and result by walking the ship's cells.
module tb_armazenando_pecas;

    localparam int NP = 2;

    logic       clk = 1'b0;
    logic       reset, enable, limpar, valida, jogador, direcao, orientacao;
    logic [2:0] tipo, X1, Y1;
    logic       conflito, pronto, ocupado, ocupada;
    logic [1:0] completo;
    logic       consulta_jogador;
    logic [2:0] consulta_x, consulta_y;

    int n_cmp  = 0;
    int n_fail = 0;

    bit [63:0] mb [2];
    int        cnt [2];

    always #5 clk = ~clk;

    armazenando_pecas #(.NUM_PECAS(NP)) dut (
        .clk(clk), .reset(reset), .enable(enable), .limpar(limpar),
        .valida(valida), .tipo(tipo), .jogador(jogador), .X1(X1), .Y1(Y1),
        .direcao(direcao), .orientacao(orientacao), .conflito(conflito),
        .pronto(pronto), .ocupado(ocupado), .completo(completo),
        .consulta_jogador(consulta_jogador), .consulta_x(consulta_x),
        .consulta_y(consulta_y), .ocupada(ocupada)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit occ(input int j, input int x, input int y);
        if (x < 0 || x > 7 || y < 0 || y > 7) return 1'b0;
        return mb[j][y*8 + x];
    endfunction

    function automatic bit touches(input int j, input int x, input int y);
`ifdef ADJACENCIA_EN
        for (int ddy = -1; ddy <= 1; ddy++)
            for (int ddx = -1; ddx <= 1; ddx++)
                if (occ(j, x + ddx, y + ddy)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic void predict(input int t, input int j, input int x, input int y,
                                    input int d, input int o,
                                    output int lat, output bit conf);
        int len, px, py, step;
        if (t > 4 || cnt[j] >= NP) begin
            lat = 1; conf = 1'b1; return;
        end
        len = 5 - t;
        for (int k = 0; k < len; k++) begin
            step = o ? -k : k;
            px = d ? x : x + step;
            py = d ? y + step : y;
            if (px < 0 || px > 7 || py < 0 || py > 7 || occ(j, px, py) || touches(j, px, py)) begin
                lat = k + 2; conf = 1'b1; return;
            end
        end
        lat = 2*len + 1; conf = 1'b0;
    endfunction

    function automatic void commit(input int t, input int j, input int x, input int y,
                                   input int d, input int o);
        int step;
        for (int k = 0; k < 5 - t; k++) begin
            step = o ? -k : k;
            if (d) mb[j][(y + step)*8 + x] = 1'b1;
            else   mb[j][y*8 + x + step] = 1'b1;
        end
        cnt[j]++;
    endfunction

    function automatic void model_clear();
        mb[0] = '0; mb[1] = '0; cnt[0] = 0; cnt[1] = 0;
    endfunction

    // Presents a request and returns at the negedge of cycle 1.
    task automatic start_req(input int t, input int j, input int x, input int y,
                             input int d, input int o);
        @(negedge clk);
        tipo = 3'(t); jogador = 1'(j); X1 = 3'(x); Y1 = 3'(y);
        direcao = 1'(d); orientacao = 1'(o);
        enable = 1'b1; valida = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valida = 1'b0;
    endtask

    task automatic req(input string tag, input int t, input int j, input int x, input int y,
                       input int d, input int o);
        int lat_exp, lat, c;
        bit conf_exp, busy_ok, seen;
        predict(t, j, x, y, d, o, lat_exp, conf_exp);
        start_req(t, j, x, y, d, o);
        lat = 0; c = 1; busy_ok = 1'b1; seen = 1'b0;
        while (!seen && c <= 20) begin
            if (ocupado !== 1'b1) busy_ok = 1'b0;
            if (pronto === 1'b1) begin
                seen = 1'b1; lat = c;
                valida = 1'b0; enable = 1'b1;
            end else begin
                // Busy-time noise on inputs that must be ignored or already captured
                valida = 1'($urandom_range(0, 1));
                enable = 1'($urandom_range(0, 1));
                tipo = 3'($urandom); X1 = 3'($urandom); Y1 = 3'($urandom);
                jogador = 1'($urandom); direcao = 1'($urandom); orientacao = 1'($urandom);
                @(posedge clk);
                @(negedge clk);
                c++;
            end
        end
        valida = 1'b0;
        check({tag, ".lat"}, lat, lat_exp);
        check({tag, ".conf"}, {31'd0, conflito}, {31'd0, conf_exp});
        check({tag, ".busy"}, {31'd0, busy_ok}, 32'd1);
        if (!conf_exp) commit(t, j, x, y, d, o);
        @(posedge clk);
        #1;
        check({tag, ".completo"}, {30'd0, completo},
              {30'd0, (cnt[1] >= NP), (cnt[0] >= NP)});
        check({tag, ".idle"}, {31'd0, ocupado}, 32'd0);
    endtask

    task automatic rd(input int j, input int x, input int y, output logic v);
        @(negedge clk);
        consulta_jogador = 1'(j); consulta_x = 3'(x); consulta_y = 3'(y);
        @(posedge clk);
        @(negedge clk);
        v = ocupada;
    endtask

    task automatic board_cmp(input string tag);
        int bad;
        logic v;
        bad = 0;
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < 64; k++) begin
                rd(j, k % 8, k / 8, v);
                if (v !== mb[j][k]) bad++;
            end
        check(tag, bad, 0);
    endtask

    task automatic pulse_limpar();
        @(negedge clk);
        limpar = 1'b1;
        @(posedge clk);
        @(negedge clk);
        limpar = 1'b0;
        model_clear();
    endtask

    initial begin
        logic v;
        model_clear();
        reset = 1'b0; enable = 1'b0; limpar = 1'b0; valida = 1'b0;
        tipo = '0; jogador = 1'b0; X1 = '0; Y1 = '0; direcao = 1'b0; orientacao = 1'b0;
        consulta_jogador = 1'b0; consulta_x = '0; consulta_y = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.pronto", {31'd0, pronto}, 32'd0);
        check("rst.ocupado", {31'd0, ocupado}, 32'd0);
        check("rst.conflito", {31'd0, conflito}, 32'd0);
        check("rst.completo", {30'd0, completo}, 32'd0);
        check("rst.ocupada", {31'd0, ocupada}, 32'd0);
        reset = 1'b1;

        // Ship 1 and read-port spot checks
        req("ship1", 0, 0, 2, 2, 0, 0);
        rd(0, 6, 2, v); check("rd62", {31'd0, v}, 32'd1);
        rd(0, 7, 2, v); check("rd72", {31'd0, v}, 32'd0);

        req("overlap", 1, 0, 4, 0, 1, 0);
        board_cmp("board.after_overlap");

        // Bounds and invalid type
        req("bound_hi", 0, 0, 5, 5, 0, 0);
        req("bound_lo", 3, 0, 0, 7, 0, 1);
        req("bad_tipo", 6, 0, 3, 3, 0, 0);

        // Adjacency to ship 1
        req("adjacent", 4, 0, 7, 3, 0, 0);

        // enable low blocks acceptance
        @(negedge clk);
        enable = 1'b0; valida = 1'b1; tipo = 3'd4;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("en_gate", {31'd0, ocupado}, 32'd0);
        end
        valida = 1'b0; enable = 1'b1;

        // Completion of player 1
        pulse_limpar();
        req("p1_a", 2, 1, 0, 0, 0, 0);
        req("p1_b", 3, 1, 0, 5, 1, 0);
        check("completo10", {30'd0, completo}, 32'd2);
        req("p1_full", 4, 1, 7, 7, 0, 0);

        // Reset in the middle of CHECK
        rd(1, 0, 5, v);
        start_req(0, 0, 0, 3, 0, 0);
        #2 reset = 1'b0;
        #1;
        check("arst.pronto", {31'd0, pronto}, 32'd0);
        check("arst.ocupado", {31'd0, ocupado}, 32'd0);
        check("arst.conflito", {31'd0, conflito}, 32'd0);
        check("arst.completo", {30'd0, completo}, 32'd0);
        check("arst.ocupada", {31'd0, ocupada}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        board_cmp("board.after_reset");

        // limpar during WRITE
        req("pre_limpar", 1, 1, 3, 3, 1, 1);
        start_req(0, 0, 1, 1, 0, 0);
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
        end
        limpar = 1'b1;
        @(posedge clk);
        @(negedge clk);
        limpar = 1'b0;
        model_clear();
        check("limpar.pronto", {31'd0, pronto}, 32'd0);
        check("limpar.ocupado", {31'd0, ocupado}, 32'd0);
        check("limpar.conflito", {31'd0, conflito}, 32'd0);
        board_cmp("board.after_limpar");

        // Randomized requests against the model
        for (int n = 0; n < 160; n++) begin
            int t;
            if ($urandom_range(0, 14) == 0) pulse_limpar();
            t = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
            req("rand", t, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            if (n % 40 == 39) board_cmp("board.rand");
        end
        board_cmp("board.final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/armazenando_pecas.md
# armazenando_pecas

Board-storage and conflict-checking responder for the ship-placement phase. It accepts one placement request per `valida` handshake from the placement controller and walks the ship cell by cell against the selected player's 8x8 board. It answers with `conflito` plus a one-cycle `pronto`, and on success commits the ship to the board. It also counts accepted ships per player and provides a registered read port for the attack phase.

## Interface
Parameters:
- `NUM_PECAS`, default 5: ships per player; once reached, `completo[j]` is set and further requests for player j are rejected.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  gates acceptance of new requests only.
- `limpar`  in  1  synchronous clear of boards, counters and `conflito`.
- `valida`  in  1  request strobe, sampled only in IDLE.
- `tipo`  in  3  ship type: 0 = length 5, 1 = length 4, 2 = length 3, 3 = length 2, 4 = length 1. Values 5–7 are invalid.
- `jogador`  in  1  target board.
- `X1`, `Y1`  in  3 each  first cell of the ship.
- `direcao`  in  1  0 = horizontal (X varies), 1 = vertical (Y varies).
- `orientacao`  in  1  0 = increasing coordinate, 1 = decreasing coordinate.
- `conflito`  out  1  result of the last completed request; held until the next acceptance.
- `pronto`  out  1  one-cycle completion pulse.
- `ocupado`  out  1  high whenever state ≠ IDLE.
- `completo`  out  2  bit j set when player j has NUM_PECAS ships.
- `consulta_jogador`  in  1  read-port player select.
- `consulta_x`, `consulta_y`  in  3 each  read-port cell.
- `ocupada`  out  1  registered board bit at index Y*8+X.

## Operation
- Storage: two 64-bit boards. Bit index is Y*8+X.
- States: IDLE, CHECK, WRITE, DONE.
- IDLE: when `enable`=1 and `valida`=1, capture all request inputs and length L, clear cell index i, and clear `conflito`.
  - If `tipo`>4 or `completo[jogador]`=1: go to DONE with conflict flag set.
  - Otherwise: go to CHECK.
- Cell i coordinate: varying coordinate = {1'b0,start} + i (orientacao 0) or − i (orientacao 1), computed in 4 bits. Bit 3 set means out of board; this covers both 0−1 = 15 and 7+1 = 8.
- CHECK, one cell per cycle:
  - Cell out of board or already occupied: go to DONE with conflict flag set.
  - Cell good and i = L−1: go to WRITE with i = 0.
  - Cell good otherwise: increment i.
- WRITE: set one cell bit per cycle. At i = L−1, go to DONE.
- DONE: assert `pronto`, drive `conflito` = flag. If no conflict, increment the player counter and set `completo[j]` when the counter equals NUM_PECAS. Return to IDLE.
- `valida` outside IDLE is ignored. Dropping `enable` mid-operation does not abort it.
- `limpar`:
  - Has priority over everything.
  - Zeroes boards, counters, `completo` and `conflito`.
  - Forces IDLE without a `pronto` pulse.
- Reset: every output is 0, both boards are 0, and the state is IDLE.

## Timing
- Cycle 0 is the edge on which `valida` is accepted.
- Success: CHECK occupies cycles 1..L, WRITE occupies cycles L+1..2L, and `pronto` is high in cycle 2L+1.
- Conflict at cell k: `pronto` is high in cycle k+2.
- Invalid type or completed player: `pronto` is high in cycle 1.
- `ocupado` is high from cycle 1 through the `pronto` cycle inclusive. The next request can be accepted the cycle after `pronto`.
- Read port: `ocupada` is valid one cycle after the address. It is read-before-write: a cell written on the same edge appears one cycle later.

## Configuration
- `ADJACENCIA_EN` defined: each CHECK cell also conflicts if any of its 8 in-board neighbours is occupied on the target board, so ships may not touch. Out-of-board neighbours are ignored. Latency is unchanged.
- `ADJACENCIA_EN` undefined: only overlap and bounds are checked.

## Test plan
- Place ship 1: player 0, tipo 0, X1=2, Y1=2, direcao 0, orientacao 0 → `pronto` at cycle 11, `conflito`=0. Read-port results: (6,2) → 1, (7,2) → 0.
- With ship 1 present, place tipo 1 at X1=4, Y1=0, direcao 1, orientacao 0 → conflict at k=2, `pronto` at cycle 4, `conflito`=1, board unchanged.
- Bounds: tipo 0 at X1=5 horizontal increasing → `pronto` at cycle 5 with `conflito`=1. Tipo 3 at X1=0, Y1=7 horizontal decreasing → `pronto` at cycle 3 with `conflito`=1. Tipo 6 → `pronto` at cycle 1 with `conflito`=1.
- Adjacency: tipo 4 at (7,3) next to ship 1 → `conflito`=1 with `ADJACENCIA_EN` defined, `conflito`=0 without it.
- NUM_PECAS=2: after two accepted ships for player 1, `completo`=2'b10. A third request for player 1 → `pronto` at cycle 1 with `conflito`=1.
- Assert `limpar` during WRITE → no `pronto`, `ocupado`=0 next cycle, all boards read 0. Asserting `reset` low mid-CHECK → all outputs 0 immediately.
